regfile_writeback: RTL

//  Write-back stage for register_file: collects results from the ALU and memory

---
 rtl/regfile_writeback.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Write-back queue in front of the register file's single write port: accepts up to
// two results per cycle (MEM older than ALU), retires one per cycle. WB_FORWARD_EN adds the pending-result lookup.
module regfile_writeback #(
  parameter int REG_W      = 32,
  parameter int REG_COUNT  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int REG_IDX_W = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [REG_W-1:0]     alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [REG_W-1:0]     mem_data,
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_reg,
  output logic [REG_W-1:0]     wr_data,
  input  logic [REG_IDX_W-1:0] fwd_reg,
  output logic                 fwd_hit,
  output logic [REG_W-1:0]     fwd_data,
  output logic                 idle
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_IDX_W-1:0] r_rd   [FIFO_DEPTH];
  logic [REG_W-1:0]     r_data [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count;

  logic             w_mem_push, w_alu_push, w_pop;
  logic [PTR_W-1:0] w_alu_wptr;

  // Readiness looks only at the registered count so producers see no comb path from valids.
  assign mem_ready  = (r_count <= CNT_W'(FIFO_DEPTH - 1));
  assign alu_ready  = (r_count <= CNT_W'(FIFO_DEPTH - 2));
  assign w_mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign w_pop      = (r_count != '0);
  assign w_alu_wptr = r_wptr + PTR_W'(w_mem_push);
  assign idle       = (r_count == '0) && !wr_en;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      if (w_mem_push) begin
        r_rd[r_wptr]   <= mem_rd;
        r_data[r_wptr] <= mem_data;
      end
      if (w_alu_push) begin
        r_rd[w_alu_wptr]   <= alu_rd;
        r_data[w_alu_wptr] <= alu_data;
      end
      r_wptr  <= r_wptr + PTR_W'(w_mem_push) + PTR_W'(w_alu_push);
      r_count <= r_count + CNT_W'(w_mem_push) + CNT_W'(w_alu_push) - CNT_W'(w_pop);
      wr_en   <= w_pop;
      if (w_pop) begin
        wr_reg  <= r_rd[r_rptr];
        wr_data <= r_data[r_rptr];
        r_rptr  <= r_rptr + PTR_W'(1);
      end
    end
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to newest so the youngest matching entry overrides older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = r_rptr;
    if (wr_en && (wr_reg == fwd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_idx = r_rptr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_rd[w_idx] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[w_idx];
      end
    end
    if (fwd_reg == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_reg;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule
